// File: rtl/upcounter_sequencer.sv
// upcounter_sequencer: run/pause/one-shot controller issuing clear/step/direction strobes to an external LED counter.
// Define COUNTER_STEP_EN to add the `step` input for single-stepping while paused.
module upcounter_sequencer #(
  parameter int COUNT_WIDTH = 12,
  parameter int COUNT       = 999,
  parameter int LED_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
`ifdef COUNTER_STEP_EN
  input  logic                 step,
`endif
  input  logic                 dir_sel,
  input  logic                 oneshot,
  input  logic [LED_WIDTH-1:0] limit,
  input  logic [LED_WIDTH-1:0] cnt_val,
  output logic                 cnt_clr,
  output logic                 cnt_en,
  output logic                 cnt_up,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           state
);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, DONE = 2'b11} st_t;
  st_t                   st;
  logic [COUNT_WIDTH-1:0] pres;
  logic                   oneshot_q;
  logic [LED_WIDTH-1:0]   limit_q;
  logic                   tick;
  logic                   stp;
`ifdef COUNTER_STEP_EN
  assign stp = step;
`else
  assign stp = 1'b0;
`endif
  assign tick  = (st == RUN) && (pres == COUNT_WIDTH'(COUNT));
  assign state = st;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st        <= IDLE;
      pres      <= '0;
      oneshot_q <= 1'b0;
      limit_q   <= '0;
      cnt_clr   <= 1'b0;
      cnt_en    <= 1'b0;
      cnt_up    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      cnt_clr <= 1'b0;
      cnt_en  <= 1'b0;
      case (st)
        IDLE, DONE: begin
          if (stop && st == DONE) begin
            st   <= IDLE;
            done <= 1'b0;
          end else if (start && !stop) begin
            st        <= RUN;
            pres      <= '0;
            cnt_up    <= dir_sel;
            oneshot_q <= oneshot;
            limit_q   <= limit;
            cnt_clr   <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
          end
        end
        RUN: begin
          pres <= tick ? '0 : pres + 1'b1;
          if (stop) begin
            st   <= PAUSE;
            pres <= '0;
          end else if (tick && oneshot_q && cnt_val == limit_q) begin
            st   <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
          end else if (tick) begin
            cnt_en <= 1'b1;
          end
        end
        PAUSE: begin
          // prescaler is already 0 here, so resuming gives a full step period
          if (stop) begin
            st   <= IDLE;
            busy <= 1'b0;
          end else if (start) begin
            st <= RUN;
          end else if (stp) begin
            cnt_en <= 1'b1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_upcounter_sequencer.sv
// tb_upcounter_sequencer: scoreboard bench for upcounter_sequencer with a behavioural 8-bit counter.
module tb_upcounter_sequencer;
  logic       clk = 1'b0, rst = 1'b0, start = 1'b0, stop = 1'b0, step = 1'b0;
  logic       dir_sel = 1'b0, oneshot = 1'b0;
  logic [7:0] limit = 8'd0, cv;
  logic       cnt_clr, cnt_en, cnt_up, busy, done;
  logic [1:0] state;
  int         tests = 0, fails = 0, clash = 0, gap;
  logic [7:0] exp_q[$];
  logic [7:0] e;

  upcounter_sequencer #(.COUNT_WIDTH(12), .COUNT(3), .LED_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
`ifdef COUNTER_STEP_EN
    .step(step),
`endif
    .dir_sel(dir_sel), .oneshot(oneshot), .limit(limit), .cnt_val(cv),
    .cnt_clr(cnt_clr), .cnt_en(cnt_en), .cnt_up(cnt_up), .busy(busy), .done(done), .state(state)
  );

  always #40 clk = ~clk;

  always @(posedge clk or negedge rst)
    if (!rst) cv <= 8'd0;
    else if (cnt_clr) cv <= 8'd0;
    else if (cnt_en) cv <= cnt_up ? cv + 8'd1 : cv - 8'd1;

  always @(negedge clk) if (cnt_clr && cnt_en) clash++;

  task automatic wait_en(input int budget, output int g);
    g = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (cnt_en) begin g = i; return; end
    end
  endtask

  task automatic pulse(input logic s, input logic p);
    @(negedge clk); start = s; stop = p;
    @(negedge clk); start = 1'b0; stop = 1'b0;
  endtask

  task automatic drain(input string nm);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wait_en(8, gap);
      tests++; if (gap !== 4) begin fails++; $display("FAIL %s_gap: got %0d expected 4", nm, gap); end
      @(posedge clk); #1;
      tests++; if (cv !== e) begin fails++; $display("FAIL %s_val: got %0d expected %0d", nm, cv, e); end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    tests++; if ({cnt_clr, cnt_en, cnt_up, busy, done, state} !== 7'b0) begin fails++; $display("FAIL reset_out: got %b expected 0", {cnt_clr, cnt_en, cnt_up, busy, done, state}); end
    @(negedge clk); rst = 1'b1;
    dir_sel = 1'b1;
    pulse(1'b1, 1'b0);
    repeat (2) @(negedge clk);
    tests++; if (state !== 2'b01 || busy !== 1'b1) begin fails++; $display("FAIL reset_run: got state %b busy %b expected 01 1", state, busy); end
    #10 rst = 1'b0;
    #1;
    tests++; if ({cnt_clr, cnt_en, cnt_up, busy, done, state} !== 7'b0) begin fails++; $display("FAIL reset_async: got %b expected 0", {cnt_clr, cnt_en, cnt_up, busy, done, state}); end
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    tests++; if (state !== 2'b00) begin fails++; $display("FAIL reset_idle: got %b expected 00", state); end
  endtask

  task automatic test_freerun;
    dir_sel = 1'b1; oneshot = 1'b0;
    pulse(1'b1, 1'b0);
    tests++; if (cnt_clr !== 1'b1) begin fails++; $display("FAIL free_clr: got %b expected 1", cnt_clr); end
    for (int i = 1; i <= 258; i++) exp_q.push_back(8'(i));
    drain("free");
    pulse(1'b0, 1'b1); pulse(1'b0, 1'b1);
    tests++; if (state !== 2'b00 || cv !== 8'd2) begin fails++; $display("FAIL free_abort: got state %b val %0d expected 00 2", state, cv); end
  endtask

  task automatic test_oneshot;
    dir_sel = 1'b1; oneshot = 1'b1; limit = 8'd5;
    pulse(1'b1, 1'b0);
    tests++; if (cnt_clr !== 1'b1) begin fails++; $display("FAIL os_clr: got %b expected 1", cnt_clr); end
    for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
    drain("os");
    wait_en(8, gap);
    tests++; if (gap !== -1) begin fails++; $display("FAIL os_extra_en: got gap %0d expected none", gap); end
    tests++; if ({done, busy, state} !== 4'b1011 || cv !== 8'd5) begin fails++; $display("FAIL os_done: got done %b busy %b state %b val %0d expected 1 0 11 5", done, busy, state, cv); end
    pulse(1'b0, 1'b1);
    tests++; if (state !== 2'b00 || done !== 1'b0) begin fails++; $display("FAIL os_stop: got state %b done %b expected 00 0", state, done); end
  endtask

  task automatic test_pause;
    dir_sel = 1'b1; oneshot = 1'b0;
    pulse(1'b1, 1'b0);
    exp_q.push_back(8'd1); exp_q.push_back(8'd2);
    drain("pre_pause");
    pulse(1'b0, 1'b1);
    tests++; if (state !== 2'b10 || busy !== 1'b1) begin fails++; $display("FAIL pause_state: got %b busy %b expected 10 1", state, busy); end
    wait_en(20, gap);
    tests++; if (gap !== -1 || cv !== 8'd2) begin fails++; $display("FAIL pause_hold: got gap %0d val %0d expected none 2", gap, cv); end
    pulse(1'b1, 1'b0);
    exp_q.push_back(8'd3);
    drain("resume");
    pulse(1'b0, 1'b1);
    tests++; if (state !== 2'b10) begin fails++; $display("FAIL pause_again: got %b expected 10", state); end
    pulse(1'b0, 1'b1);
    tests++; if (state !== 2'b00 || busy !== 1'b0 || cv !== 8'd3) begin fails++; $display("FAIL pause_abort: got state %b busy %b val %0d expected 00 0 3", state, busy, cv); end
  endtask

  task automatic test_both;
    pulse(1'b1, 1'b1);
    tests++; if (state !== 2'b00 || cnt_clr !== 1'b0) begin fails++; $display("FAIL both_idle: got state %b clr %b expected 00 0", state, cnt_clr); end
    dir_sel = 1'b1; oneshot = 1'b0;
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b1);
    tests++; if (state !== 2'b10) begin fails++; $display("FAIL both_run: got %b expected 10", state); end
    pulse(1'b0, 1'b1);
    dir_sel = 1'b0; oneshot = 1'b1; limit = 8'd250;
    pulse(1'b1, 1'b0);
    tests++; if (cnt_clr !== 1'b1) begin fails++; $display("FAIL down_clr: got %b expected 1", cnt_clr); end
    for (int i = 255; i >= 250; i--) exp_q.push_back(8'(i));
    drain("down");
    wait_en(8, gap);
    tests++; if (gap !== -1 || state !== 2'b11 || done !== 1'b1 || cv !== 8'd250) begin fails++; $display("FAIL down_done: got gap %0d state %b done %b val %0d expected none 11 1 250", gap, state, done, cv); end
  endtask

  task automatic test_limit0;
    dir_sel = 1'b1; oneshot = 1'b1; limit = 8'd0;
    pulse(1'b1, 1'b0);
    tests++; if (cnt_clr !== 1'b1 || state !== 2'b01 || done !== 1'b0) begin fails++; $display("FAIL restart: got clr %b state %b done %b expected 1 01 0", cnt_clr, state, done); end
    wait_en(8, gap);
    tests++; if (gap !== -1 || state !== 2'b11 || cv !== 8'd0) begin fails++; $display("FAIL lim0_up: got gap %0d state %b val %0d expected none 11 0", gap, state, cv); end
    pulse(1'b0, 1'b1);
    dir_sel = 1'b0;
    pulse(1'b1, 1'b0);
    wait_en(8, gap);
    tests++; if (gap !== -1 || state !== 2'b11 || cv !== 8'd0) begin fails++; $display("FAIL lim0_dn: got gap %0d state %b val %0d expected none 11 0", gap, state, cv); end
    pulse(1'b0, 1'b1);
  endtask

  task automatic test_step;
`ifdef COUNTER_STEP_EN
    dir_sel = 1'b1; oneshot = 1'b0;
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk); step = 1'b1;
      @(negedge clk); step = 1'b0;
      tests++; if (cnt_en !== 1'b1 || state !== 2'b10) begin fails++; $display("FAIL step_en: got en %b state %b expected 1 10", cnt_en, state); end
      @(posedge clk); #1;
      tests++; if (cv !== 8'(k)) begin fails++; $display("FAIL step_val: got %0d expected %0d", cv, k); end
    end
    pulse(1'b0, 1'b1);
    @(negedge clk); step = 1'b1;
    @(negedge clk); step = 1'b0;
    tests++; if (cnt_en !== 1'b0 || state !== 2'b00) begin fails++; $display("FAIL step_idle: got en %b state %b expected 0 00", cnt_en, state); end
`endif
  endtask

  task automatic test_exclusive;
    tests++; if (clash !== 0) begin fails++; $display("FAIL clr_en_overlap: got %0d expected 0", clash); end
  endtask

  initial begin
    test_reset;
    test_freerun;
    test_oneshot;
    test_pause;
    test_both;
    test_limit0;
    test_step;
    test_exclusive;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
